// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile_n register file: default geometry,
// counter-op encoding and the select-width helper.
package regfile_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Counter op encoding on cnt_op; 2'b11 is not a member and means "no op".
   typedef enum logic [1:0] {
      CNT_NONE = 2'b00,
      CNT_INC  = 2'b01,
      CNT_DEC  = 2'b10
   } cnt_op_t;

   // Width of every select field: ceil(log2(depth)), never below one bit.
   function automatic int sel_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_n_if.sv
// Control/status bundle of regfile_n. The controller side uses the master
// modport, the register file uses the slave modport. The shared data bus is
// a separate inout port on regfile_n because it is truly bidirectional.
interface regfile_n_if
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int SELW = sel_w(DEPTH);

   logic                   load;
   logic [SELW-1:0]        load_sel;
   logic                   assert_en;
   logic [SELW-1:0]        assert_sel;
   logic [1:0]             cnt_op;
   logic [SELW-1:0]        cnt_sel;
   logic [DEPTH*WIDTH-1:0] contents;
   logic [DEPTH-1:0]       zero;
   logic                   wrap;

   modport master (
      output load, load_sel, assert_en, assert_sel, cnt_op, cnt_sel,
      input  contents, zero, wrap
   );

   modport slave (
      input  load, load_sel, assert_en, assert_sel, cnt_op, cnt_sel,
      output contents, zero, wrap
   );

endinterface

// File: rtl/regfile_n_gpr_cell.sv
// gpr_cell: one general-purpose register with load-over-count priority,
// modulo-2^WIDTH increment/decrement and a registered wrap flag.
module gpr_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld,
   input  logic             inc,
   input  logic             dec,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   // Next value: load wins over counting; wrap only when a count is applied.
   always_comb begin
      q_next    = q;
      wrap_next = 1'b0;
      if (ld) begin
         q_next = d;
      end else if (inc) begin
         q_next    = q + ONE;
         wrap_next = (q == {WIDTH{1'b1}});
      end else if (dec) begin
         q_next    = q - ONE;
         wrap_next = (q == {WIDTH{1'b0}});
      end
   end

   // Register and wrap flag, cleared immediately by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q      <= '0;
         wrap_o <= 1'b0;
      end else begin
         q      <= q_next;
         wrap_o <= wrap_next;
      end
   end

endmodule

// File: rtl/regfile_n.sv
// regfile_n: DEPTH x WIDTH register file on a shared bidirectional bus with
// one load port, one combinational assert port and an in-place counter.
// Build option: define REGFILE_INCDEC_EN to enable the counter unit and the
// wrap flag; without it cnt_op/cnt_sel are ignored and wrap is always 0.
module regfile_n
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   regfile_n_if.slave       rf,
   inout  wire [WIDTH-1:0]  dbus
);

   logic [WIDTH-1:0] q [DEPTH];
   logic [DEPTH-1:0] ld_vec;
   logic [DEPTH-1:0] inc_vec;
   logic [DEPTH-1:0] dec_vec;
   logic [DEPTH-1:0] wrap_vec;
   logic [WIDTH-1:0] rd_val;
   logic             rd_hit;
   logic             drive;

   // Select decode; out-of-range selects match no register and are dropped.
   always_comb begin
      ld_vec  = '0;
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ld_vec[i] = rf.load && (int'(rf.load_sel) == i);
`ifdef REGFILE_INCDEC_EN
         inc_vec[i] = (rf.cnt_op == CNT_INC) && (int'(rf.cnt_sel) == i);
         dec_vec[i] = (rf.cnt_op == CNT_DEC) && (int'(rf.cnt_sel) == i);
`endif
      end
   end

   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_cell
         gpr_cell #(.WIDTH(WIDTH)) u_cell (
            .clk    (clk),
            .reset  (reset),
            .ld     (ld_vec[g]),
            .inc    (inc_vec[g]),
            .dec    (dec_vec[g]),
            .d      (dbus),
            .q      (q[g]),
            .wrap_o (wrap_vec[g])
         );
         assign rf.contents[g*WIDTH +: WIDTH] = q[g];
         assign rf.zero[g]                    = (q[g] == '0);
      end
   endgenerate

`ifdef REGFILE_INCDEC_EN
   assign rf.wrap = |wrap_vec;
`else
   // Counter inputs and cell wrap flags are intentionally unused here.
   logic unused_cnt;
   assign unused_cnt = ^{rf.cnt_op, rf.cnt_sel, wrap_vec};
   assign rf.wrap    = 1'b0;
`endif

   // Assert source mux; rd_hit is low for an out-of-range select.
   always_comb begin
      rd_val = '0;
      rd_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (int'(rf.assert_sel) == i) begin
            rd_val = q[i];
            rd_hit = 1'b1;
         end
      end
   end

   // The bus is released during reset and for invalid selects. A load of the
   // asserted register therefore captures its own value (self-transfer).
   assign drive = rf.assert_en && rd_hit && !reset;
   assign dbus  = drive ? rd_val : {WIDTH{1'bz}};

endmodule
